// File: rtl/serial_sub8_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and default width.
package serial_sub8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_bitcell.sv
// Combinational 1-bit full adder used as the serial subtractor's arithmetic slice.
module serial_bitcell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_sub8.sv
// Bit-serial a - b: computes a + ~b + 1 one bit per cycle, LSB first, over WIDTH cycles.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module serial_sub8
    import serial_sub8_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_nb;
    logic [WIDTH-1:0] r_dsh;
    logic [WIDTH-1:0] r_diff;
    logic             r_carry;
    logic             r_borrow;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;
    logic             w_sum;
    logic             w_cout;
    logic             w_last;

    serial_bitcell u_bitcell (
        .a    (r_a[0]),
        .b    (r_nb[0]),
        .cin  (r_carry),
        .s    (w_sum),
        .cout (w_cout)
    );

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_next = ST_RUN;
            ST_RUN:  if (w_last)    w_next = ST_DONE;
            ST_DONE: if (out_ready) w_next = ST_IDLE;
            default:                w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_nb     <= '0;
            r_dsh    <= '0;
            r_diff   <= '0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_nb    <= ~b;
                        r_carry <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_nb    <= {1'b0, r_nb[WIDTH-1:1]};
                    r_dsh   <= {w_sum, r_dsh[WIDTH-1:1]};
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    // Results are published only on the MSB cycle so they stay put while running.
                    if (w_last) begin
                        r_diff   <= {w_sum, r_dsh[WIDTH-1:1]};
                        r_borrow <= ~w_cout;
                        r_ovf    <= r_carry ^ w_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign diff      = r_diff;
    assign borrow    = r_borrow;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_sub8.sv
// Directed bench for serial_sub8: vector table plus hold, reset and in-run stimulus sequences.
module tb_serial_sub8;
    import serial_sub8_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    logic         busy;
    logic [1:0]   dbg_state;

    int total;
    int bad;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } vec_t;

    vec_t vecs[7];

    serial_sub8 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction; hold = cycles out_ready stays low in DONE, toggle = churn inputs during RUN.
    task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] ed, input logic eb, input logic eo,
                         input int hold, input bit toggle);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        a         = va;
        b         = vb;
        tick();
        in_valid = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        chk("in_ready_low_in_run", {31'd0, in_ready}, 32'd0);
        n = 0;
        while (n < 20) begin
            n++;
            if (toggle) begin
                in_valid = 1'b1;
                a        = W'($urandom_range(0, 255));
                b        = W'($urandom_range(0, 255));
            end
            tick();
            if (out_valid) break;
        end
        in_valid = 1'b0;
        chk("latency", n, W);
        chk("diff", {24'd0, diff}, {24'd0, ed});
        chk("borrow", {31'd0, borrow}, {31'd0, eb});
        chk("ovf", {31'd0, ovf}, {31'd0, eo});
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_diff", {24'd0, diff}, {24'd0, ed});
            chk("hold_borrow", {31'd0, borrow}, {31'd0, eb});
        end
        out_ready = 1'b1;
        tick();
        chk("out_valid_after_take", {31'd0, out_valid}, 32'd0);
        chk("state_idle_after_take", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        chk("in_ready_after_take", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_diff"}, {24'd0, diff}, 32'd0);
        chk({tag, "_borrow"}, {31'd0, borrow}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
        chk({tag, "_state"}, {30'd0, dbg_state}, {30'd0, ST_IDLE});
    endtask

    initial begin
        int seen;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;

        vecs[0] = '{a: 8'd200,  b: 8'd55,   diff: 8'd145,  borrow: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'd5,    b: 8'd10,   diff: 8'd251,  borrow: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h80,   b: 8'h01,   diff: 8'h7F,   borrow: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: 8'h00,   b: 8'h00,   diff: 8'h00,   borrow: 1'b0, ovf: 1'b0};
        vecs[4] = '{a: 8'h7F,   b: 8'hFF,   diff: 8'h80,   borrow: 1'b1, ovf: 1'b1};
        vecs[5] = '{a: 8'hFF,   b: 8'h01,   diff: 8'hFE,   borrow: 1'b0, ovf: 1'b0};
        vecs[6] = '{a: 8'h00,   b: 8'h80,   diff: 8'h80,   borrow: 1'b1, ovf: 1'b1};

        #2;
        chk_reset_vals("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        foreach (vecs[i])
            do_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, vecs[i].ovf, 0, 1'b0);

        // Consumer stalls for five cycles in DONE.
        do_op(8'd77, 8'd33, 8'd44, 1'b0, 1'b0, 5, 1'b0);

        // Reset in the middle of RUN, after three bits have been processed.
        in_valid = 1'b1;
        a        = 8'd200;
        b        = 8'd55;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("busy_before_reset", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrun_reset");
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) rst_n = 1'b1;
            tick();
            if (out_valid) seen++;
        end
        chk("no_result_after_reset", seen, 0);
        do_op(8'd9, 8'd4, 8'd5, 1'b0, 1'b0, 0, 1'b0);

        // Inputs churn throughout RUN; result must be unaffected.
        do_op(8'd100, 8'd30, 8'd70, 1'b0, 1'b0, 0, 1'b1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("no_extra_out_valid", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_sub8.md
SERIAL_SUB8 -- requirements
Module: serial_sub8

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand pair offered.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: a  input  WIDTH  minuend, unsigned / two's complement.
REQ-007 SHALL have port: b  input  WIDTH  subtrahend.
REQ-008 SHALL have port: out_valid  output  1  result available.
REQ-009 SHALL have port: out_ready  input  1  consumer takes result.
REQ-010 SHALL have port: diff  output  WIDTH  a - b modulo 2^WIDTH.
REQ-011 SHALL have port: borrow  output  1  1 when a < b unsigned.
REQ-012 SHALL have port: ovf  output  1  signed overflow of a - b.
REQ-013 SHALL have port: busy  output  1  high in RUN or DONE.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE.
REQ-016 SHALL accept operands on the edge where in_valid & in_ready: latch a and ~b into shift registers, carry flop = 1, bit counter = 0, go to RUN.
REQ-017 SHALL in RUN process one bit per cycle, LSB first: sum = a0 ^ nb0 ^ c, c' = majority(a0, nb0, c); shift sum into diff register from MSB side.
REQ-018 SHALL stay in RUN exactly WIDTH cycles, then enter DONE; out_valid rises WIDTH edges after the accepting edge.
REQ-019 SHALL in DONE hold out_valid = 1 with diff, borrow, ovf stable until out_ready = 1.
REQ-020 SHALL set borrow = ~(final carry) and ovf = carry into MSB XOR carry out of MSB.
REQ-021 SHALL return to IDLE on the edge where out_valid & out_ready; in_ready asserts the following cycle (no same-cycle accept in DONE).
REQ-022 SHALL ignore in_valid and a/b changes while in RUN or DONE.
REQ-023 SHALL hold diff/borrow/ovf at last result values in IDLE and RUN; they are only meaningful while out_valid = 1.
REQ-024 SHALL treat out_ready outside DONE as don't-care.

Reset
REQ-025 SHALL on rst_n = 0 immediately force state IDLE, in_ready = 1, out_valid = 0, busy = 0, diff = 0, borrow = 0, ovf = 0, counter and shift registers = 0.
REQ-026 SHALL abandon any in-flight operation on reset with no result produced.
REQ-027 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Structure
REQ-028 SHALL place state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and default WIDTH in a shared header/package used by block and bench.
REQ-029 SHALL instantiate one sub-module, serial_bitcell, a combinational 1-bit full adder (a, b, cin -> s, cout) fed by the inverted-subtrahend bit and the carry flop.
REQ-030 SHALL size the bit counter to $clog2(WIDTH+1) bits.

Verification
REQ-031 SHALL test: a=200, b=55, out_ready=1 -> out_valid 8 edges after accept, diff=145, borrow=0, ovf=0.
REQ-032 SHALL test: a=5, b=10 -> diff=251, borrow=1, ovf=0.
REQ-033 SHALL test: a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1; a=0x00, b=0x00 -> diff=0, borrow=0.
REQ-034 SHALL test: out_ready low 5 cycles in DONE -> out_valid and diff held stable; release -> IDLE next edge, in_ready=1 one cycle later.
REQ-035 SHALL test: rst_n pulsed low at bit 3 of RUN -> outputs at reset values at once; new a=9, b=4 afterward -> diff=5.
REQ-036 SHALL test: in_valid toggled with new operands during RUN -> result unaffected, no extra out_valid pulse.
